// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus of cla_pipe_adder: valid/ready operand side, valid/ready result side.
// The adder side uses the slave modport; the producer/consumer side uses master.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one SEG-bit two-level CLA segment per rank, result after STAGES edges, one per cycle.
// Backpressure: any held result (out_valid & ~out_ready) freezes every rank and drops in_ready.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave io_bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / BLOCK;

    typedef struct packed {
        logic [SEG-1:0] sum;
        logic           cout;
    } seg_res_t;

    // Group G/P per BLOCK bits, then every group carry-in is formed directly from c_in and all lower G/P.
    function automatic seg_res_t seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c_in
    );
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  c;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        logic            pr;
        logic            rc;
        seg_res_t        r;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int k = 0; k < BLOCK; k++) begin
                gg[j] = g[j*BLOCK+k] | (p[j*BLOCK+k] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+k];
            end
        end
        gc[0] = c_in;
        for (int j = 0; j < NGRP; j++) begin
            pr = 1'b1;
            for (int m = 0; m <= j; m++) begin
                pr = pr & gp[m];
            end
            gc[j+1] = pr & c_in;
            for (int m = 0; m <= j; m++) begin
                pr = gg[m];
                for (int q = m + 1; q <= j; q++) begin
                    pr = pr & gp[q];
                end
                gc[j+1] = gc[j+1] | pr;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            rc = gc[j];
            for (int k = 0; k < BLOCK; k++) begin
                c[j*BLOCK+k] = rc;
                rc = g[j*BLOCK+k] | (p[j*BLOCK+k] & rc);
            end
        end
        r.sum  = p ^ c;
        r.cout = gc[NGRP];
        return r;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_adv           = ~(r_out_vld & ~io_bus.out_ready);
    assign io_bus.in_ready = w_adv;
    assign w_b_eff         = io_bus.sub ? ~io_bus.b : io_bus.b;
    assign w_c0            = io_bus.cin ^ io_bus.sub;

    // Carry ranks: each evaluates one segment, keeps the finished low result bits and
    // skews the not-yet-used upper operand bits forward alongside the registered carry.
    for (genvar g = 0; g < STAGES - 1; g++) begin : g_rank
        localparam int HI = (g + 1) * SEG;

        logic [SEG-1:0]      w_sa;
        logic [SEG-1:0]      w_sb;
        logic                w_sc;
        logic                w_svld;
        logic [HI-1:0]       w_slo_nxt;
        logic [WIDTH-HI-1:0] w_ahi_nxt;
        logic [WIDTH-HI-1:0] w_bhi_nxt;
        seg_res_t            w_res;

        logic                r_vld;
        logic                r_c;
        logic [HI-1:0]       r_slo;
        logic [WIDTH-HI-1:0] r_ahi;
        logic [WIDTH-HI-1:0] r_bhi;

        if (g == 0) begin : g_src
            assign w_sa      = io_bus.a[SEG-1:0];
            assign w_sb      = w_b_eff[SEG-1:0];
            assign w_sc      = w_c0;
            assign w_svld    = io_bus.in_valid & w_adv;
            assign w_ahi_nxt = io_bus.a[WIDTH-1:SEG];
            assign w_bhi_nxt = w_b_eff[WIDTH-1:SEG];
            assign w_slo_nxt = w_res.sum;
        end else begin : g_src
            assign w_sa      = g_rank[g-1].r_ahi[SEG-1:0];
            assign w_sb      = g_rank[g-1].r_bhi[SEG-1:0];
            assign w_sc      = g_rank[g-1].r_c;
            assign w_svld    = g_rank[g-1].r_vld;
            assign w_ahi_nxt = g_rank[g-1].r_ahi[WIDTH-g*SEG-1:SEG];
            assign w_bhi_nxt = g_rank[g-1].r_bhi[WIDTH-g*SEG-1:SEG];
            assign w_slo_nxt = {w_res.sum, g_rank[g-1].r_slo};
        end

        assign w_res = seg_add(w_sa, w_sb, w_sc);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_slo <= '0;
                r_ahi <= '0;
                r_bhi <= '0;
            end else if (w_adv) begin
                r_vld <= w_svld;
                r_c   <= w_res.cout;
                r_slo <= w_slo_nxt;
                r_ahi <= w_ahi_nxt;
                r_bhi <= w_bhi_nxt;
            end
        end
    end

    logic [SEG-1:0]   w_fa;
    logic [SEG-1:0]   w_fb;
    logic             w_fc;
    logic             w_fvld;
    logic [WIDTH-1:0] w_s_nxt;
    logic             w_ovf_nxt;
    seg_res_t         w_fres;

    if (STAGES == 1) begin : g_last
        assign w_fa    = io_bus.a;
        assign w_fb    = w_b_eff;
        assign w_fc    = w_c0;
        assign w_fvld  = io_bus.in_valid & w_adv;
        assign w_s_nxt = w_fres.sum;
    end else begin : g_last
        assign w_fa    = g_rank[STAGES-2].r_ahi;
        assign w_fb    = g_rank[STAGES-2].r_bhi;
        assign w_fc    = g_rank[STAGES-2].r_c;
        assign w_fvld  = g_rank[STAGES-2].r_vld;
        assign w_s_nxt = {w_fres.sum, g_rank[STAGES-2].r_slo};
    end

    assign w_fres = seg_add(w_fa, w_fb, w_fc);
    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    assign w_ovf_nxt = w_fa[SEG-1] ^ w_fb[SEG-1] ^ w_fres.sum[SEG-1] ^ w_fres.cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_s       <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_adv) begin
            r_out_vld <= w_fvld;
            r_s       <= w_s_nxt;
            r_cout    <= w_fres.cout;
            r_ovf     <= w_ovf_nxt;
            r_zero    <= (w_s_nxt == '0);
        end
    end

    assign io_bus.out_valid = r_out_vld;
    assign io_bus.s         = r_s;
    assign io_bus.cout      = r_cout;
    assign io_bus.ovf       = r_ovf;
    assign io_bus.zero      = r_zero;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Three adder configurations (32/4/2, 16/4/1, 64/8/4) driven in lockstep from shared stimulus,
// each scored against an arithmetic reference model through its own expected-result queue.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t_vld  = 1'b0;
    logic        t_ordy = 1'b1;
    logic [63:0] t_a    = '0;
    logic [63:0] t_b    = '0;
    logic        t_cin  = 1'b0;
    logic        t_sub  = 1'b0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic lat_chk = 1'b0;

    const int W   [3] = '{32, 16, 64};
    const int STG [3] = '{2, 1, 4};

    typedef struct packed {
        logic [66:0] res;
        int          cyc;
        logic        lat;
    } ent_t;
    ent_t sbq [3][$];

    cla_pipe_adder_if #(.WIDTH(32)) if0 ();
    cla_pipe_adder_if #(.WIDTH(16)) if1 ();
    cla_pipe_adder_if #(.WIDTH(64)) if2 ();

    assign if0.in_valid = t_vld;  assign if0.a = t_a[31:0]; assign if0.b = t_b[31:0];
    assign if0.cin = t_cin;       assign if0.sub = t_sub;   assign if0.out_ready = t_ordy;
    assign if1.in_valid = t_vld;  assign if1.a = t_a[15:0]; assign if1.b = t_b[15:0];
    assign if1.cin = t_cin;       assign if1.sub = t_sub;   assign if1.out_ready = t_ordy;
    assign if2.in_valid = t_vld;  assign if2.a = t_a;       assign if2.b = t_b;
    assign if2.cin = t_cin;       assign if2.sub = t_sub;   assign if2.out_ready = t_ordy;

    cla_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
    cla_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .io_bus(if1.slave));
    cla_pipe_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut2 (.clk(clk), .rst(rst), .io_bus(if2.slave));

    // Reference: {ovf, zero, cout, s} from wide integer arithmetic and sign rules.
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [64:0] mask;
        logic [64:0] sum;
        logic [63:0] be;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (65'd1 << w) - 65'd1;
        be   = sub ? ~b : b;
        sum  = ({1'b0, a} & mask) + ({1'b0, be} & mask) + 65'(cin ^ sub);
        co   = sum[w];
        s    = sum[63:0] & mask[63:0];
        ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
        return {ov, (s == 64'd0), co, s};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s got=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        logic        rdy;
        logic        ov;
        logic [66:0] obs;
        ent_t        e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin rdy = if0.in_ready; ov = if0.out_valid;
                         obs = {if0.ovf, if0.zero, if0.cout, 64'(if0.s)}; end
                1: begin rdy = if1.in_ready; ov = if1.out_valid;
                         obs = {if1.ovf, if1.zero, if1.cout, 64'(if1.s)}; end
                default: begin rdy = if2.in_ready; ov = if2.out_valid;
                         obs = {if2.ovf, if2.zero, if2.cout, if2.s}; end
            endcase
            if (rst) begin
                sbq[k].delete();
            end else begin
                if (ov && t_ordy) begin
                    if (sbq[k].size() == 0) begin
                        chk($sformatf("unexpected_out_dut%0d", k), 80'(ov), 80'(0));
                    end else begin
                        e = sbq[k].pop_front();
                        chk($sformatf("result_dut%0d", k), 80'(obs), 80'(e.res));
                        if (e.lat) chk($sformatf("latency_dut%0d", k), 80'(cyc - e.cyc), 80'(STG[k]));
                    end
                end
                if (t_vld && rdy) begin
                    e.res = model(W[k], t_a, t_b, t_cin, t_sub);
                    e.cyc = cyc;
                    e.lat = lat_chk;
                    sbq[k].push_back(e);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_in();
        t_vld = 1'b1;
        t_a   = {$urandom, $urandom};
        t_b   = {$urandom, $urandom};
        t_cin = 1'($urandom_range(0, 1));
        t_sub = 1'($urandom_range(0, 1));
    endtask

    const logic [63:0] DA [6] = '{64'h1, 64'h7FFF_FFFF, 64'h5, 64'h0000_FFFF, 64'h0001_0000, 64'h8000_0000};
    const logic [63:0] DB [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h7, 64'h1, 64'h0, 64'h1};
    const logic        DC [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    const logic        DS [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // {cout, ovf, zero, s[31:0]} expected from the 32-bit instance
    const logic [34:0] DE [6] = '{35'h5_0000_0000, 35'h2_8000_0000, 35'h0_FFFF_FFFE,
                                  35'h0_0001_0000, 35'h4_0000_FFFF, 35'h6_7FFF_FFFF};

    logic [35:0] snap;

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out0", 80'({if0.out_valid, if0.cout, if0.ovf, if0.zero, if0.s}), 80'(0));
        chk("rst_out1", 80'({if1.out_valid, if1.cout, if1.ovf, if1.zero, if1.s}), 80'(0));
        chk("rst_out2", 80'({if2.out_valid, if2.cout, if2.ovf, if2.zero, if2.s}), 80'(0));
        chk("rst_in_ready", 80'({if0.in_ready, if1.in_ready, if2.in_ready}), 80'(3'b111));

        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            t_vld = 1'b1; t_a = DA[i]; t_b = DB[i]; t_cin = DC[i]; t_sub = DS[i];
            step();
            t_vld = 1'b0;
            step();
            chk("directed_32", 80'({if0.out_valid, if0.cout, if0.ovf, if0.zero, if0.s}), 80'({1'b1, DE[i]}));
        end
        t_vld = 1'b0;
        for (int i = 0; i < 5; i++) step();

        for (int i = 0; i < 10; i++) begin
            rand_in();
            step();
        end
        t_vld = 1'b0;
        for (int i = 0; i < 6; i++) step();
        for (int k = 0; k < 3; k++) chk($sformatf("drain_stream_dut%0d", k), 80'(sbq[k].size()), 80'(0));

        lat_chk = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin
                t_ordy = 1'b0;
                #1;
                snap = {if0.out_valid, if0.cout, if0.ovf, if0.zero, if0.s};
                chk("stall_out_valid", 80'(if0.out_valid), 80'(1));
            end
            if (i == 8) t_ordy = 1'b1;
            rand_in();
            step();
            if (i >= 5 && i < 8) begin
                chk("stall_frozen", 80'({if0.out_valid, if0.cout, if0.ovf, if0.zero, if0.s}), 80'(snap));
                chk("stall_in_ready", 80'({if0.in_ready, if1.in_ready, if2.in_ready}), 80'(0));
            end
        end
        t_vld = 1'b0;
        for (int i = 0; i < 6; i++) step();
        for (int k = 0; k < 3; k++) chk($sformatf("drain_stall_dut%0d", k), 80'(sbq[k].size()), 80'(0));

        rand_in();
        step();
        rand_in();
        step();
        t_vld = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 80'({if0.out_valid, if1.out_valid, if2.out_valid}), 80'(0));
        chk("flush_in_ready", 80'({if0.in_ready, if1.in_ready, if2.in_ready}), 80'(3'b111));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_stale_out", 80'({if0.out_valid, if1.out_valid, if2.out_valid}), 80'(0));
        end

        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_in();
            step();
        end
        t_vld = 1'b0;
        for (int i = 0; i < 6; i++) step();
        for (int k = 0; k < 3; k++) chk($sformatf("drain_final_dut%0d", k), 80'(sbq[k].size()), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined successor to the team's fixed 32-bit carry-lookahead adder. Adds or subtracts two WIDTH-bit operands using BLOCK-bit lookahead groups, split into STAGES register ranks with carries registered between ranks. A valid/ready handshake with backpressure and a flag output (carry, signed overflow, zero) let it sit directly in the ALU datapath.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of BLOCK*STAGES
BLOCK, 4, bits per lookahead group (generate/propagate computed per group)
STAGES, 2, register ranks (>=1); segment width SEG = WIDTH/STAGES

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
cout  output  1  raw carry out of MSB
ovf  output  1  signed two's-complement overflow
zero  output  1  s == 0

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high, sampled only on the rising edge of clk.
- Reset: all rank valid bits, out_valid, s, cout, ovf and zero cleared to 0 on the edge rst is sampled high; in_ready is 1 in the cycle after reset. Reset mid-operation discards all in-flight transactions; none emerge afterwards.
- Arithmetic: b_eff = sub ? ~b : b; c0 = cin ^ sub. s = a + b_eff + c0 (mod 2^WIDTH).
  - sub=0: a+b+cin. sub=1,cin=0: a-b. sub=1,cin=1: a-b-1.
  - cout = carry out of bit WIDTH-1 (for sub: 1 = no borrow).
  - ovf = carry into MSB XOR carry out of MSB. zero = (s == 0).
- Structure: segment i (bits [i*SEG +: SEG]) evaluated in rank i. Inside a segment: per-bit g=a&b_eff, p=a^b_eff; per-group G/P over BLOCK bits; second-level lookahead across groups for group carry-ins. Segment carry-out registered into rank i+1. Upper operand segments and sub-derived b_eff delayed (skewed) to reach their rank with matching carry; lower result segments delayed to align at output. Last rank registers s, cout, ovf, zero.
- Latency: transaction accepted at edge k (in_valid & in_ready) appears with out_valid=1 after edge k+STAGES-1, i.e. exactly STAGES cycles later absent stalls. Throughput one per cycle.
- Handshake:
  - stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
  - On stall, every rank and the output hold; s/cout/ovf/zero stable while out_valid=1 and out_ready=0.
  - Not stalled: all ranks advance; rank 0 valid loads in_valid & in_ready.
  - Bubbles propagate as valid=0 ranks; no collapsing required.
  - Result consumed on edge where out_valid & out_ready; simultaneous accept of a new input in the same cycle is allowed (full-rate streaming).
- in_valid=0: a, b, cin, sub ignored; output data when out_valid=0 is don't-care except after reset (0).
- Boundary: all-ones + 1 wraps to 0 with cout=1, zero=1. No X propagation from data inputs into valid bits.

Test Plan:
- Reset then a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 -> after 2 cycles s=0x0000_0000, cout=1, ovf=0, zero=1.
- a=0x7FFF_FFFF, b=0x0000_0001, add -> s=0x8000_0000, ovf=1, cout=0; then a=5, b=7, sub=1, cin=0 -> s=0xFFFF_FFFE, cout=0, ovf=0.
- Carry crossing rank boundary: a=0x0000_FFFF, b=0x0000_0001, cin=0 -> s=0x0001_0000; with cin=1 and sub=1, a=0x0001_0000, b=0 -> s=0x0000_FFFF.
- Stream 10 back-to-back random transactions with out_ready=1 -> 10 results in order, one per cycle, matching reference model; then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs frozen, no loss/duplication.
- Assert rst for one cycle with 2 transactions in flight -> out_valid=0 next cycle and no stale results ever appear.
- Re-run stream test for (WIDTH=16,BLOCK=4,STAGES=1) and (WIDTH=64,BLOCK=8,STAGES=4) -> latency 1 and 4 respectively, results correct.
